// File: rtl/byte_word_packer.sv
// Packs a valid/ready byte stream into 32-bit words with lane mask, last flag and word counter.
// Define BYTE_WORD_PACKER_MSB_FIRST_EN to place the first byte of each word in [31:24].
module byte_word_packer #(
   parameter logic [7:0]  PAD_BYTE = 8'h00,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [7:0]       in_byte_i,
   input  logic             in_last_i,
   output logic             word_valid_o,
   input  logic             word_ready_i,
   output logic [31:0]      word_data_o,
   output logic [3:0]       word_mask_o,
   output logic             word_last_o,
   output logic [CNT_W-1:0] word_count_o
);

   logic [23:0]      acc_q, acc_d;
   logic [1:0]       cnt_q, cnt_d;
   logic             valid_q, valid_d;
   logic [31:0]      data_q, data_d;
   logic [3:0]       mask_q, mask_d;
   logic             last_q, last_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic        accept;
   logic        form;
   logic        drain;
   logic [31:0] acc_ext;
   logic [31:0] word_new;
   logic [3:0]  mask_new;
   logic [7:0]  lane;

   // A slot frees up either when empty or when the held word leaves this cycle.
   assign in_ready_o = ~valid_q | word_ready_i;
   assign accept     = in_valid_i & in_ready_o;
   assign form       = accept & ((cnt_q == 2'd3) | in_last_i);
   assign drain      = valid_q & word_ready_i;
   assign acc_ext    = {8'h00, acc_q};

   // Lane k in arrival order: pending bytes, then the incoming byte, then padding.
   always_comb begin
      word_new = '0;
      mask_new = '0;
      lane     = PAD_BYTE;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(cnt_q)) begin
            lane = acc_ext[8*k +: 8];
         end else if (k == int'(cnt_q)) begin
            lane = in_byte_i;
         end else begin
            lane = PAD_BYTE;
         end
`ifdef BYTE_WORD_PACKER_MSB_FIRST_EN
         word_new[8*(3-k) +: 8] = lane;
         mask_new[3-k]          = (k <= int'(cnt_q));
`else
         word_new[8*k +: 8] = lane;
         mask_new[k]        = (k <= int'(cnt_q));
`endif
      end
   end

   always_comb begin
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      data_d  = data_q;
      mask_d  = mask_q;
      last_d  = last_q;
      count_d = count_q;

      if (accept) begin
         if (form) begin
            cnt_d = 2'd0;
         end else begin
            case (cnt_q)
               2'd0:    acc_d[7:0]   = in_byte_i;
               2'd1:    acc_d[15:8]  = in_byte_i;
               2'd2:    acc_d[23:16] = in_byte_i;
               default: acc_d        = acc_q;
            endcase
            cnt_d = cnt_q + 2'd1;
         end
      end

      // A fresh word overrides a simultaneous drain so valid stays high.
      if (form) begin
         valid_d = 1'b1;
         data_d  = word_new;
         mask_d  = mask_new;
         last_d  = in_last_i;
      end else if (drain) begin
         valid_d = 1'b0;
      end

      if (drain) begin
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         mask_q  <= '0;
         last_q  <= 1'b0;
         count_q <= '0;
      end else begin
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         last_q  <= last_d;
         count_q <= count_d;
      end
   end

   assign word_valid_o = valid_q;
   assign word_data_o  = data_q;
   assign word_mask_o  = mask_q;
   assign word_last_o  = last_q;
   assign word_count_o = count_q;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: vector table of packets plus backpressure, reset and wrap cases.
module tb_byte_word_packer;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [7:0]       in_byte = 8'h00;
   logic             in_last = 1'b0;
   logic             word_valid;
   logic             word_ready = 1'b1;
   logic [31:0]      word_data;
   logic [3:0]       word_mask;
   logic             word_last;
   logic [CNT_W-1:0] word_count;

   int checks = 0;
   int errors = 0;

   logic        mon_en = 1'b0;
   logic [32:0] mon_q[$];

   typedef struct {
      logic [7:0]  b [4];
      int          n;
      logic [31:0] data;
      logic [3:0]  mask;
   } vec_t;

   vec_t vecs [4];

   always #5 clk = ~clk;

   byte_word_packer #(
      .PAD_BYTE (8'h5A),
      .CNT_W    (CNT_W)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_byte_i    (in_byte),
      .in_last_i    (in_last),
      .word_valid_o (word_valid),
      .word_ready_i (word_ready),
      .word_data_o  (word_data),
      .word_mask_o  (word_mask),
      .word_last_o  (word_last),
      .word_count_o (word_count)
   );

   // Handshake at the following posedge; inputs only change just after posedges.
   always @(negedge clk) begin
      if (mon_en && rst_n && word_valid && word_ready) mon_q.push_back({word_last, word_data});
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h required %08h", name, act, exp);
      end
   endtask

   task automatic drive_byte(input logic [7:0] b, input logic last);
      bit done;
      done     = 1'b0;
      in_valid = 1'b1;
      in_byte  = b;
      in_last  = last;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         done = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout byte %02h: in_ready stayed 0, required 1", b);
      end
   endtask

   task automatic set_vec(input int idx, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3, input int n,
                          input logic [31:0] data, input logic [3:0] mask);
      vecs[idx].b[0] = b0;
      vecs[idx].b[1] = b1;
      vecs[idx].b[2] = b2;
      vecs[idx].b[3] = b3;
      vecs[idx].n    = n;
      vecs[idx].data = data;
      vecs[idx].mask = mask;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      check("rst_valid", word_valid, 0);
      check("rst_count", word_count, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic [31:0] w0, w1, w_rst;
      bit seen;

`ifdef BYTE_WORD_PACKER_MSB_FIRST_EN
      set_vec(0, 8'h11, 8'h22, 8'h33, 8'h44, 4, 32'h11223344, 4'b1111);
      set_vec(1, 8'hAA, 8'hBB, 8'h00, 8'h00, 2, 32'hAABB5A5A, 4'b1100);
      set_vec(2, 8'hC1, 8'h00, 8'h00, 8'h00, 1, 32'hC15A5A5A, 4'b1000);
      set_vec(3, 8'h11, 8'h22, 8'h33, 8'h00, 3, 32'h1122335A, 4'b1110);
      w0    = 32'h01020304;
      w1    = 32'h05060708;
      w_rst = 32'h30313233;
`else
      set_vec(0, 8'h11, 8'h22, 8'h33, 8'h44, 4, 32'h44332211, 4'b1111);
      set_vec(1, 8'hAA, 8'hBB, 8'h00, 8'h00, 2, 32'h5A5ABBAA, 4'b0011);
      set_vec(2, 8'hC1, 8'h00, 8'h00, 8'h00, 1, 32'h5A5A5AC1, 4'b0001);
      set_vec(3, 8'h11, 8'h22, 8'h33, 8'h00, 3, 32'h5A332211, 4'b0111);
      w0    = 32'h04030201;
      w1    = 32'h08070605;
      w_rst = 32'h33323130;
`endif

      // Reset state
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", word_valid, 0);
      check("rst_data", word_data, 0);
      check("rst_mask", word_mask, 0);
      check("rst_last", word_last, 0);
      check("rst_count", word_count, 0);
      check("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Table of packets, downstream always ready
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < vecs[i].n; j++) begin
            drive_byte(vecs[i].b[j], (j == vecs[i].n - 1));
            if (j < vecs[i].n - 1) check($sformatf("vec%0d_no_early_word", i), word_valid, 0);
         end
         check($sformatf("vec%0d_valid", i), word_valid, 1);
         check($sformatf("vec%0d_data", i), word_data, vecs[i].data);
         check($sformatf("vec%0d_mask", i), word_mask, vecs[i].mask);
         check($sformatf("vec%0d_last", i), word_last, 1);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_drained", i), word_valid, 0);
         check($sformatf("vec%0d_count", i), word_count, 32'(i + 1));
      end

      // Backpressure: 8 bytes streamed, downstream stalls 3 cycles after first word
      mon_q.delete();
      mon_en = 1'b1;
      fork
         begin
            for (int k = 1; k <= 8; k++) drive_byte(8'(k), (k == 8));
         end
         begin
            seen = 1'b0;
            for (int t = 0; t < 50 && !seen; t++) begin
               @(posedge clk);
               #2;
               seen = word_valid;
            end
            check("bp_first_word_seen", 32'(seen), 1);
            word_ready = 1'b0;
            repeat (3) begin
               @(negedge clk);
               check("bp_in_ready_low", in_ready, 0);
               check("bp_data_hold", word_data, w0);
               @(posedge clk);
               #2;
            end
            word_ready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("bp_word_total", mon_q.size(), 2);
      if (mon_q.size() >= 2) begin
         check("bp_word0_data", mon_q[0][31:0], w0);
         check("bp_word0_last", mon_q[0][32], 0);
         check("bp_word1_data", mon_q[1][31:0], w1);
         check("bp_word1_last", mon_q[1][32], 1);
      end
      check("bp_count", word_count, 6);

      // Reset mid-packet discards pending bytes and counter
      drive_byte(8'h10, 1'b0);
      drive_byte(8'h20, 1'b0);
      do_reset();
      mon_q.delete();
      mon_en = 1'b1;
      for (int k = 0; k < 4; k++) drive_byte(8'h30 + 8'(k), (k == 3));
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b0;
      check("rstmid_word_total", mon_q.size(), 1);
      if (mon_q.size() >= 1) begin
         check("rstmid_word_data", mon_q[0][31:0], w_rst);
         check("rstmid_word_last", mon_q[0][32], 1);
      end
      check("rstmid_count", word_count, 1);

      // Counter wrap with CNT_W = 4
      do_reset();
      for (int k = 0; k < 15; k++) drive_byte(8'(k), 1'b1);
      @(posedge clk);
      #1;
      check("wrap_count_15", word_count, 15);
      drive_byte(8'hF0, 1'b1);
      @(posedge clk);
      #1;
      check("wrap_count_0", word_count, 0);
      check("wrap_drained", word_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
